// File: rtl/keypad_decoder.sv
// ---------------------------------------------------------------------------
// keypad_decoder
// This block sits on the consumer side of the keypad scanner. It confirms
// that a key press is stable, decodes the {rows, columns} code to a hex
// digit, and shifts that digit into a two-digit history for the dual
// seven-segment display. It does not accept another key until the current
// key has been released cleanly.
//
// Parameters:
//   DEBOUNCE_CYCLES : number of stable cycles needed to accept a press or
//                     release (2..65535)
//
// Ports:
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   enable      : scanner strobe, one cycle at the start of a candidate press
//   key_pressed : level, high while any column is active
//   key_code    : {rows[3:0], columns[3:0]}, one-hot per nibble, and bit 3
//                 of each nibble is index 0
//   digit_new   : most recently accepted hex digit
//   digit_old   : digit accepted before digit_new
//   key_valid   : one-cycle pulse in the cycle the digits update
//   key_err     : one-cycle pulse on an invalid code (KEYPAD_ERR_EN only)
//   busy        : high whenever the FSM is not idle
//
// Build option:
//   KEYPAD_ERR_EN : when defined, key_err reports invalid codes. When it is
//                   undefined, key_err is held at 0.
// ---------------------------------------------------------------------------
module keypad_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       key_pressed,
  input  logic [7:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid,
  output logic       key_err,
  output logic       busy
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CODE_W = 8;
  localparam int unsigned DIG_W  = 4;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_COMMIT,
    ST_HELD,
    ST_RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [DIG_W-1:0]  dig_new_q, dig_new_d;
  logic [DIG_W-1:0]  dig_old_q, dig_old_d;
  logic              key_valid_q, key_valid_d;
  logic              key_err_q, key_err_d;
  logic              busy_q, busy_d;

  logic              code_ok_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Returns 1 when exactly one bit of the nibble is set.
  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Converts a one-hot nibble to an index, where bit 3 is index 0.
  function automatic logic [1:0] idx4(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b1000: r = 2'd0;
      4'b0100: r = 2'd1;
      4'b0010: r = 2'd2;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Keypad layout: row0 1 2 3 A, row1 4 5 6 B, row2 7 8 9 C, row3 E 0 F D.
  function automatic logic [DIG_W-1:0] decode(input logic [CODE_W-1:0] code);
    logic [DIG_W-1:0] d;
    case ({idx4(code[7:4]), idx4(code[3:0])})
      4'h0: d = 4'h1;  4'h1: d = 4'h2;  4'h2: d = 4'h3;  4'h3: d = 4'hA;
      4'h4: d = 4'h4;  4'h5: d = 4'h5;  4'h6: d = 4'h6;  4'h7: d = 4'hB;
      4'h8: d = 4'h7;  4'h9: d = 4'h8;  4'hA: d = 4'h9;  4'hB: d = 4'hC;
      4'hC: d = 4'hE;  4'hD: d = 4'h0;  4'hE: d = 4'hF;  default: d = 4'hD;
    endcase
    return d;
  endfunction

  assign code_ok_c = onehot4(key_code[7:4]) && onehot4(key_code[3:0]);
  // The counter saturates at all-ones. The FSM leaves each counting state
  // at its terminal count, so saturation is only a safety net.
  assign cnt_inc_c = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      dig_new_q   <= '0;
      dig_old_q   <= '0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      dig_new_q   <= dig_new_d;
      dig_old_q   <= dig_old_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic and next values for the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    dig_new_d   = dig_new_q;
    dig_old_d   = dig_old_q;
    key_valid_d = 1'b0;
    key_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (code_ok_c) begin
            code_d  = key_code;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
`ifdef KEYPAD_ERR_EN
            key_err_d = 1'b1;
`endif
          end
        end
      end

      // A drop or a code change aborts silently. Otherwise count stable cycles.
      ST_DEBOUNCE: begin
        if (!key_pressed || (key_code != code_q)) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_TERM) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      ST_COMMIT: begin
        dig_old_d   = dig_new_q;
        dig_new_d   = decode(code_q);
        key_valid_d = 1'b1;
        state_d     = ST_HELD;
      end

      ST_HELD: begin
        if (!key_pressed) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      // A bounce back to pressed returns to HELD, so a second commit cannot occur.
      ST_RELEASE: begin
        if (key_pressed) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_TERM) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_c;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign digit_new = dig_new_q;
  assign digit_old = dig_old_q;
  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_decoder.sv
module tb_keypad_decoder;

  localparam int unsigned D = 4;
  localparam int L = 20;
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       key_pressed = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic [3:0] digit_new, digit_old;
  logic       key_valid, key_err, busy;

  keypad_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .enable(enable), .key_pressed(key_pressed),
    .key_code(key_code), .digit_new(digit_new), .digit_old(digit_old),
    .key_valid(key_valid), .key_err(key_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] nw;
    logic [3:0] od;
  } exp_t;

  exp_t       exp_q[$];
  int         err_pending = 0;
  int         checks = 0;
  int         fails = 0;
  logic [3:0] m_new = 4'h0;
  logic [3:0] m_old = 4'h0;
  logic       prev_kv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit onehot(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int pos(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[3-i]) return i;
    return 0;
  endfunction

  // Monitor: pops one expectation per key_valid pulse and per key_err pulse.
  always @(negedge clk) begin
    if (!reset) begin
      prev_kv = 1'b0;
    end else begin
      if (key_valid) begin
        chk("kv_back_to_back", 32'(prev_kv), 32'd0);
        chk("kv_err_same_cycle", 32'(key_err), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_key_valid: got digits %0h/%0h expected none", digit_new, digit_old);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("digit_new", 32'(digit_new), 32'(e.nw));
          chk("digit_old", 32'(digit_old), 32'(e.od));
        end
      end
      if (key_err) begin
        checks++;
        if (err_pending == 0) begin
          fails++;
          $display("FAIL unexpected_key_err: got 1 expected 0");
        end else begin
          err_pending--;
        end
      end
      prev_kv = key_valid;
    end
  end

  // One candidate press. H is the first edge at which key_pressed is low.
  // g is the first edge with a changed code (0 means the code never changes).
  // When bounce is set, key_pressed returns high for one cycle during release.
  task automatic press(input logic [7:0] code, input int H, input int g, input bit bounce);
    bit valid, commit, errexp;
    int rel, idle_edge, abort;
    valid  = onehot(code[7:4]) && onehot(code[3:0]);
    commit = valid && (H > int'(D)) && (g == 0 || g > int'(D));
    errexp = 1'b0;
`ifdef KEYPAD_ERR_EN
    errexp = !valid;
`endif
    rel = (H > int'(D) + 2) ? H : int'(D) + 2;
    if (!valid) begin
      idle_edge = 0;
    end else if (commit) begin
      idle_edge = bounce ? rel + 3 + int'(D) : rel + int'(D);
    end else begin
      abort = (H < 1) ? 1 : H;
      if (g != 0 && g < abort) abort = g;
      idle_edge = abort;
    end
    if (commit) begin
      m_old = m_new;
      m_new = KEYMAP[pos(code[7:4])][pos(code[3:0])];
      exp_q.push_back('{nw: m_new, od: m_old});
    end
    if (errexp) err_pending++;

    @(negedge clk);
    enable      = 1'b1;
    key_code    = code;
    key_pressed = (H > 0);
    for (int e = 1; e <= L; e++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'((e - 1) < idle_edge));
      chk("key_valid_time", 32'(key_valid), 32'(commit && e == int'(D) + 2));
      chk("key_err_time", 32'(key_err), 32'(errexp && e == 1));
      enable      = 1'b0;
      key_pressed = (e < H) || (commit && bounce && e == rel + 2);
      if (g != 0 && e >= g) key_code = code ^ 8'h01;
    end
    key_pressed = 1'b0;
  endtask

  task automatic reset_mid_debounce();
    @(negedge clk);
    enable      = 1'b1;
    key_code    = 8'h44;
    key_pressed = 1'b1;
    repeat (3) begin
      @(negedge clk);
      enable = 1'b0;
    end
    #2 reset = 1'b0;
    #1;
    chk("rst_digit_new", 32'(digit_new), 32'd0);
    chk("rst_digit_old", 32'(digit_old), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_key_err", 32'(key_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    m_new = 4'h0;
    m_old = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (D + 6) @(negedge clk);
    key_pressed = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_digit_new", 32'(digit_new), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_digit_new", 32'(digit_new), 32'd0);
    chk("reset_digit_old", 32'(digit_old), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_key_valid", 32'(key_valid), 32'd0);
    chk("reset_key_err", 32'(key_err), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    press(8'b0100_0100, 10, 0, 1'b0);   // "5"
    press(8'b0001_0001, 10, 0, 1'b0);   // "D", old becomes 5
    press(8'b1000_1000, 2, 0, 1'b0);    // bounce on press
    press(8'b1000_1000, 6, 0, 1'b1);    // "1" with release bounce
    press(8'b1100_0100, 3, 0, 1'b0);    // invalid code
    press(8'b0000_0100, 3, 0, 1'b0);    // invalid, zero row nibble
    press(8'b0100_0100, 8, 2, 1'b0);    // code change aborts debounce
    press(8'b0010_0010, 0, 0, 1'b0);    // enable with key_pressed low
    press(8'b0100_0010, D + 1, 0, 1'b0); // shortest accepted hold

    reset_mid_debounce();

    for (int t = 0; t < 40; t++) begin
      logic [7:0] code;
      int H, g;
      bit b;
      if ($urandom % 4 != 0) begin
        code[7:4] = 4'b0001 << $urandom_range(0, 3);
        code[3:0] = 4'b0001 << $urandom_range(0, 3);
      end else begin
        code = 8'($urandom);
        if (onehot(code[7:4]) && onehot(code[3:0])) code[7:4] = 4'h0;
      end
      H = $urandom_range(0, 10);
      g = ($urandom % 3 == 0) ? $urandom_range(1, 6) : 0;
      b = 1'($urandom % 2);
      press(code, H, g, b);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("err_drained", 32'(err_pending), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
